// File: rtl/chip8_mem_arbiter.sv
// rtl/chip8_mem_arbiter.sv - single-port CHIP-8 RAM arbiter for loader, CPU and video
// Loader has absolute priority unless the CPU holds a lock; CPU/video alternate on ties.
module chip8_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    PRI_CPU = 2'd0,
    PRI_VID = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t r_state;
  logic   r_cpu_rv;
  logic   r_vid_rv;

  logic   w_ld_gnt;
  logic   w_cpu_gnt;
  logic   w_vid_gnt;

  // Grants are held off while reset is asserted so the RAM never sees a strobe.
  always_comb begin
    w_ld_gnt  = 1'b0;
    w_cpu_gnt = 1'b0;
    w_vid_gnt = 1'b0;
    if (rst) begin
      if (r_state == LOCKED) begin
        w_cpu_gnt = cpu_req;
      end else if (ld_req) begin
        w_ld_gnt = 1'b1;
      end else if (cpu_req && vid_req) begin
        if (r_state == PRI_VID) w_vid_gnt = 1'b1;
        else                    w_cpu_gnt = 1'b1;
      end else begin
        w_cpu_gnt = cpu_req;
        w_vid_gnt = vid_req;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_ld_gnt) begin
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (w_cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_vid_gnt) begin
      mem_addr  = vid_addr;
    end
  end

  assign ld_gnt  = w_ld_gnt;
  assign cpu_gnt = w_cpu_gnt;
  assign vid_gnt = w_vid_gnt;
  assign mem_en  = w_ld_gnt | w_cpu_gnt | w_vid_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= PRI_CPU;
      r_cpu_rv <= 1'b0;
      r_vid_rv <= 1'b0;
    end else begin
      r_cpu_rv <= w_cpu_gnt & ~cpu_we;
      r_vid_rv <= w_vid_gnt;
      case (r_state)
        LOCKED: begin
          if (!cpu_lock) r_state <= PRI_VID;
        end
        default: begin
          if (w_cpu_gnt)      r_state <= cpu_lock ? LOCKED : PRI_VID;
          else if (w_vid_gnt) r_state <= PRI_CPU;
        end
      endcase
    end
  end

  assign cpu_rvalid = r_cpu_rv;
  assign vid_rvalid = r_vid_rv;
  assign cpu_rdata  = r_cpu_rv ? mem_rdata : '0;
  assign vid_rdata  = r_vid_rv ? mem_rdata : '0;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb/tb_chip8_mem_arbiter.sv - directed bench with per-cycle reference model for chip8_mem_arbiter
module tb_chip8_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_req = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [7:0]  ld_wdata = '0;
  logic        ld_gnt;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_lock = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        vid_req = 1'b0;
  logic [11:0] vid_addr = '0;
  logic        vid_gnt;
  logic        vid_rvalid;
  logic [7:0]  vid_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  int errs = 0;
  int checks = 0;

  chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
    .vid_rdata(vid_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM instance driven by the DUT: one-cycle synchronous read
  logic [7:0] ram [4096];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: memory contents, lock flag, and who won the last CPU/video contest
  logic [7:0] model_mem [4096];
  logic       m_locked = 1'b0;
  logic       m_last_cpu = 1'b0;
  logic       m_pc = 1'b0, m_pv = 1'b0;
  logic [7:0] m_pcd = '0, m_pvd = '0;

  always @(negedge clk) begin
    logic el, ec, ev;
    logic [11:0] ea;
    logic [7:0] ed;
    el = 1'b0; ec = 1'b0; ev = 1'b0;
    if (rst) begin
      if (m_locked) ec = cpu_req;
      else if (ld_req) el = 1'b1;
      else if (cpu_req && vid_req) begin
        ev = m_last_cpu;
        ec = !m_last_cpu;
      end else begin
        ec = cpu_req;
        ev = vid_req;
      end
    end
    ea = el ? ld_addr : ec ? cpu_addr : ev ? vid_addr : 12'h000;
    ed = el ? ld_wdata : ec ? cpu_wdata : 8'h00;
    chk("ld_gnt", ld_gnt, el);
    chk("cpu_gnt", cpu_gnt, ec);
    chk("vid_gnt", vid_gnt, ev);
    chk("mem_en", mem_en, el | ec | ev);
    chk("mem_we", mem_we, el | (ec & cpu_we));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("cpu_rvalid", cpu_rvalid, rst & m_pc);
    chk("cpu_rdata", cpu_rdata, (rst && m_pc) ? m_pcd : 8'h00);
    chk("vid_rvalid", vid_rvalid, rst & m_pv);
    chk("vid_rdata", vid_rdata, (rst && m_pv) ? m_pvd : 8'h00);
    if (!rst) begin
      m_pc = 1'b0; m_pv = 1'b0; m_locked = 1'b0; m_last_cpu = 1'b0;
    end else begin
      m_pc = ec & !cpu_we;
      m_pcd = model_mem[cpu_addr];
      m_pv = ev;
      m_pvd = model_mem[vid_addr];
      if (el) model_mem[ld_addr] = ld_wdata;
      if (ec && cpu_we) model_mem[cpu_addr] = cpu_wdata;
      if (m_locked) begin
        if (!cpu_lock) begin m_locked = 1'b0; m_last_cpu = 1'b1; end
      end else if (ec) begin
        if (cpu_lock) m_locked = 1'b1;
        else          m_last_cpu = 1'b1;
      end else if (ev) begin
        m_last_cpu = 1'b0;
      end
    end
  end

  task automatic cyc(input logic l, input logic [11:0] la, input logic [7:0] ldat,
                     input logic c, input logic cw, input logic ck, input logic [11:0] ca,
                     input logic [7:0] cd, input logic v, input logic [11:0] va);
    @(posedge clk); #1;
    ld_req = l; ld_addr = la; ld_wdata = ldat;
    cpu_req = c; cpu_we = cw; cpu_lock = ck; cpu_addr = ca; cpu_wdata = cd;
    vid_req = v; vid_addr = va;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset with every requester asserting, held for two edges
  task automatic pulse_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b0;
    ld_req = 1'b1; cpu_req = 1'b1; vid_req = 1'b1; cpu_lock = 1'b1;
    #1;
    chk({tag, "_vid_rvalid"}, vid_rvalid, 1'b0);
    chk({tag, "_cpu_rvalid"}, cpu_rvalid, 1'b0);
    chk({tag, "_mem_en"}, mem_en, 1'b0);
    chk({tag, "_any_gnt"}, {ld_gnt, cpu_gnt, vid_gnt}, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ld_req = 1'b0; cpu_req = 1'b0; vid_req = 1'b0; cpu_lock = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'h00;
      model_mem[i] = 8'h00;
    end
    ld_req = 1'b1; cpu_req = 1'b1; vid_req = 1'b1;
    #3;
    chk("rst_gnts", {ld_gnt, cpu_gnt, vid_gnt}, 3'b000);
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 22'h0);
    chk("rst_rdata", {cpu_rdata, vid_rdata}, 16'h0);
    @(posedge clk); #1;
    ld_req = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
    rst = 1'b1;

    // loader program writes
    cyc(1, 12'h200, 8'hA2, 0, 0, 0, 0, 0, 0, 0);
    chk("ld0_gnt", ld_gnt, 1'b1);
    chk("ld0_we", mem_we, 1'b1);
    chk("ld0_addr", mem_addr, 12'h200);
    cyc(1, 12'h201, 8'h2A, 0, 0, 0, 0, 0, 0, 0);
    chk("ld1_gnt", ld_gnt, 1'b1);
    chk("ld0_no_rvalid", {cpu_rvalid, vid_rvalid}, 2'b00);

    // CPU read, then video read (leaves CPU favoured)
    cyc(0, 0, 0, 1, 0, 0, 12'h200, 0, 0, 0);
    chk("cpurd_gnt", cpu_gnt, 1'b1);
    idle();
    chk("cpurd_rvalid", cpu_rvalid, 1'b1);
    chk("cpurd_rdata", cpu_rdata, 8'hA2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 12'h201);
    chk("vidrd_gnt", vid_gnt, 1'b1);

    // sustained CPU/video contention alternates, starting with CPU
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 12'h200, 0, 1, 12'h201);
      chk("rr_cpu_gnt", cpu_gnt, (i % 2) == 0);
      chk("rr_vid_gnt", vid_gnt, (i % 2) == 1);
      chk("rr_vid_rvalid", vid_rvalid, (i % 2) == 0);
      chk("rr_cpu_rvalid", cpu_rvalid, (i % 2) == 1);
      if (i % 2 == 0) chk("rr_vid_rdata", vid_rdata, 8'h2A);
      else            chk("rr_cpu_rdata", cpu_rdata, 8'hA2);
    end
    idle();

    // locked multi-byte store with loader and video contending
    cyc(0, 0, 0, 1, 1, 1, 12'h300, 8'h11, 1, 12'h201);
    chk("lk0_cpu_gnt", cpu_gnt, 1'b1);
    cyc(1, 12'h050, 8'h77, 1, 1, 1, 12'h301, 8'h22, 1, 12'h201);
    chk("lk1_gnts", {ld_gnt, cpu_gnt, vid_gnt}, 3'b010);
    cyc(1, 12'h050, 8'h77, 1, 1, 0, 12'h302, 8'h33, 1, 12'h201);
    chk("lk2_gnts", {ld_gnt, cpu_gnt, vid_gnt}, 3'b010);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 12'h201);
    chk("lk_exit_vid_gnt", vid_gnt, 1'b1);

    // three-way contention from PRI_VID: loader, video, CPU
    cyc(0, 0, 0, 1, 0, 0, 12'h301, 0, 0, 0);
    chk("pv_setup_gnt", cpu_gnt, 1'b1);
    cyc(1, 12'h060, 8'h44, 1, 0, 0, 12'h300, 0, 1, 12'h302);
    chk("tri0_gnts", {ld_gnt, cpu_gnt, vid_gnt}, 3'b100);
    chk("tri0_rdata", cpu_rdata, 8'h22);
    cyc(0, 0, 0, 1, 0, 0, 12'h300, 0, 1, 12'h302);
    chk("tri1_gnts", {ld_gnt, cpu_gnt, vid_gnt}, 3'b001);
    cyc(0, 0, 0, 1, 0, 0, 12'h300, 0, 0, 0);
    chk("tri2_gnts", {ld_gnt, cpu_gnt, vid_gnt}, 3'b010);
    chk("tri2_vid_rdata", vid_rdata, 8'h33);
    idle();
    chk("tri3_cpu_rdata", cpu_rdata, 8'h11);

    // write then immediate read of the same byte
    cyc(0, 0, 0, 1, 1, 0, 12'h400, 8'h5A, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 12'h400, 0, 0, 0);
    idle();
    chk("wr_rd_data", cpu_rdata, 8'h5A);

    // reset right after a video grant drops its rvalid
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 12'h060);
    chk("prerst_vid_gnt", vid_gnt, 1'b1);
    pulse_reset("rst_vid");
    cyc(0, 0, 0, 1, 0, 0, 12'h200, 0, 1, 12'h201);
    chk("post_rst_tie_cpu", cpu_gnt, 1'b1);

    // reset from PRI_VID returns to PRI_CPU
    pulse_reset("rst_pv");
    cyc(0, 0, 0, 1, 0, 0, 12'h200, 0, 1, 12'h201);
    chk("post_rst_pv_tie_cpu", cpu_gnt, 1'b1);

    // reset clears the lock
    cyc(0, 0, 0, 1, 0, 1, 12'h200, 0, 0, 0);
    chk("lock_set_gnt", cpu_gnt, 1'b1);
    pulse_reset("rst_lk");
    cyc(1, 12'h070, 8'h99, 1, 0, 1, 12'h200, 0, 1, 12'h201);
    chk("post_rst_lk_ld_gnt", ld_gnt, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 12'h200, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 12'h070);
    idle();
    chk("ld_after_rst_data", vid_rdata, 8'h99);
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/chip8_mem_arbiter.md
# chip8_mem_arbiter

Single-port arbiter and sequencer for the CHIP-8 4 KiB main memory. It shares one synchronous RAM port (1-cycle read latency) between three requesters: the ROM loader, the CPU (fetch/execute), and the video scanner (sprite/framebuffer reads). It issues at most one memory access per clock and returns read data to the owning requester. It sits between `cpu`, the loader, the video block, and the RAM instance.

## Interface
Parameters:
- `ADDR_W`, 12: memory address width (4096 bytes).
- `DATA_W`, 8: memory data width.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `ld_req`  in  1  loader write request; held with address/data until granted.
- `ld_addr`  in  ADDR_W  loader write address.
- `ld_wdata`  in  DATA_W  loader write data.
- `ld_gnt`  out  1  loader write accepted this cycle.
- `cpu_req`  in  1  CPU access request.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_lock`  in  1  keep ownership after this grant (multi-byte ops: BCD, Fx55/Fx65).
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_gnt`  out  1  CPU access accepted this cycle.
- `cpu_rvalid`  out  1  CPU read data valid.
- `cpu_rdata`  out  DATA_W  CPU read data.
- `vid_req`  in  1  video read request (read-only).
- `vid_addr`  in  ADDR_W  video address.
- `vid_gnt`  out  1  video read accepted this cycle.
- `vid_rvalid`  out  1  video read data valid.
- `vid_rdata`  out  DATA_W  video read data.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data; valid the cycle after a read strobe.

## Operation
- The FSM has three states:
  - `PRI_CPU`: CPU wins a CPU/video tie.
  - `PRI_VID`: video wins a tie.
  - `LOCKED`: CPU exclusively owns the port.
- Grants are combinational from the current state and requests. At most one `*_gnt` is high per cycle. `mem_en` = OR of the grants. The `mem_*` fields are muxed from the granted requester; `mem_we` = 0 for video.
- Priority outside `LOCKED`: loader first, then CPU/video round-robin per state.
- Round-robin transitions:
  - CPU granted with `cpu_lock` = 0 → `PRI_VID`.
  - Video granted → `PRI_CPU`.
  - No CPU/video grant → state unchanged.
- `LOCKED` entry: CPU granted with `cpu_lock` = 1 → `LOCKED`.
- `LOCKED` behaviour:
  - Only the CPU may be granted; the loader and video stall.
  - Leave on the first cycle where `cpu_lock` = 0, regardless of `cpu_req`. That cycle may still grant a CPU request. Next state is `PRI_VID`.
- Read return: a read grant registers its owner tag. On the next cycle the matching `*_rvalid` = 1 and `*_rdata` = `mem_rdata`. The non-owner `*_rdata` is 0.
- Loader is write-only; it never gets read data.
- Addresses pass through unmodified. There is no wrap or offset arithmetic; masking to ADDR_W is the requester's job.
- A write followed by a read to the same address on the next cycle must return the new data (RAM write-first is not required because accesses are serialized).

## Timing
- Reset values: state = `PRI_CPU`; all `*_gnt`, `*_rvalid`, `mem_en`, `mem_we` = 0; `*_rdata`, `mem_addr`, `mem_wdata` = 0.
- Grant latency: 0 cycles. `gnt` is in the same cycle as `req` if the requester wins.
- Read latency: exactly 1 cycle from `gnt` to `rvalid`. `rvalid` is a 1-cycle pulse per grant.
- Back-to-back: one access per cycle sustained. A grant in cycle N+1 may overlap `rvalid` for the grant in cycle N.
- Handshake: a requester holds `req`/`addr`/`wdata` stable until `gnt`. It may deassert or change them the cycle after `gnt`.
- Reset asserted mid-operation: pending `rvalid` is dropped (no pulse after reset), the lock is cleared, and the state returns to `PRI_CPU`.
- Simultaneous requests:
  - Loader + CPU + video in `PRI_*` → loader granted.
  - Same three requests in `LOCKED` → CPU granted if it requests, else nothing.
- Starvation bound: video waits at most 1 CPU grant when unlocked and the loader is idle.

## Test plan
- Reset, then loader writes 0x0200←0xA2 and 0x0201←0x2A. Expect `ld_gnt` the same cycle each, `mem_we` = 1, and no `rvalid`.
- CPU reads 0x0200 with video idle. Expect `cpu_gnt` in cycle N, then `cpu_rvalid` = 1 and `cpu_rdata` = 0xA2 in N+1.
- CPU and video both hold requests continuously for 6 cycles. Expect grants to alternate CPU, VID, CPU, VID, …, each `rvalid` pulse routed to the correct requester.
- CPU holds `cpu_lock` for 3 writes to 0x0300–0x0302 while video and loader request. Expect only `cpu_gnt`s. Video is granted on the cycle after `cpu_lock` falls, while the loader is idle.
- Loader, CPU, and video all request in `PRI_VID`. Expect `ld_gnt` first, then video, then CPU.
- Assert `rst` = 0 in the cycle after a video read grant. Expect no `vid_rvalid`, all outputs 0, and `PRI_CPU` after release.
